// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 convolutional encoder and Viterbi decoder.
// Holds trellis constants, the symbol type and the encoder FSM states.
package viterbi_pkg;

    localparam int         K          = 3;
    localparam int         NUM_STATES = 4;
    localparam logic [2:0] G0_DEFAULT = 3'b111;
    localparam logic [2:0] G1_DEFAULT = 3'b101;

    typedef logic [1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_state_t;

    function automatic logic parity3(input logic [2:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational rate-1/2 K=3 trellis step: (u, s) -> (c0, c1, next_s).
// Ports: u_i input bit, s_i state {newest, oldest}, c0_o/c1_o code bits,
// next_s_o successor state.
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter logic [2:0] G0 = G0_DEFAULT,
    parameter logic [2:0] G1 = G1_DEFAULT
) (
    input  logic       u_i,
    input  logic [1:0] s_i,
    output logic       c0_o,
    output logic       c1_o,
    output logic [1:0] next_s_o
);

    logic [2:0] taps;

    // Bit 2 is the current input, bit 0 the oldest stored bit.
    assign taps     = {u_i, s_i};
    assign c0_o     = parity3(G0 & taps);
    assign c1_o     = parity3(G1 & taps);
    assign next_s_o = {u_i, s_i[1]};

endmodule

// File: rtl/conv_encoder_framed.sv
// Framed rate-1/2 K=3 convolutional encoder with two zero tail bits per frame.
// Ports: clk/reset (sync, active-high); in_valid/in_bit/in_last/in_ready data
// input; out_valid/out_sym/out_last/out_ready symbol output; frame_err pulses
// on truncation at MAX_FRAME_BITS; bit_count counts data bits in the frame.
module conv_encoder_framed
    import viterbi_pkg::*;
#(
    parameter int         MAX_FRAME_BITS = 64,
    parameter logic [2:0] G0             = G0_DEFAULT,
    parameter logic [2:0] G1             = G1_DEFAULT,
    localparam int        CW             = $clog2(MAX_FRAME_BITS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_bit,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out_valid,
    output logic [1:0]    out_sym,
    input  logic          out_ready,
    output logic          out_last,
    output logic          frame_err,
    output logic [CW-1:0] bit_count
);

    enc_state_t    state_q, state_d;
    logic [1:0]    s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tail_q, tail_d;
    logic          vld_q, vld_d;
    sym_t          sym_q, sym_d;
    logic          last_q, last_d;
    logic          err_q, err_d;

    logic          slot_free;
    logic          accept;
    logic          u;
    logic          c0, c1;
    logic [1:0]    s_nxt;

    // The slot can be refilled in the same cycle its symbol leaves.
    assign slot_free = !vld_q || out_ready;
    assign in_ready  = !reset && slot_free && (state_q != TAIL);
    assign accept    = in_valid && in_ready;

    // Tail bits are forced to zero to flush the trellis back to state 0.
    assign u = (state_q == TAIL) ? 1'b0 : in_bit;

    conv_enc_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .u_i      (u),
        .s_i      (s_q),
        .c0_o     (c0),
        .c1_o     (c1),
        .next_s_o (s_nxt)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        tail_d  = tail_q;
        vld_d   = vld_q;
        sym_d   = sym_q;
        last_d  = last_q;
        err_d   = 1'b0;

        if (vld_q && out_ready) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    vld_d  = 1'b1;
                    sym_d  = {c0, c1};
                    last_d = 1'b0;
                    s_d    = s_nxt;
                    cnt_d  = CW'(1);
                    tail_d = 1'b0;
                    if (in_last || (MAX_FRAME_BITS == 1)) begin
                        state_d = TAIL;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    vld_d  = 1'b1;
                    sym_d  = {c0, c1};
                    last_d = 1'b0;
                    s_d    = s_nxt;
                    cnt_d  = cnt_q + CW'(1);
                    if (in_last) begin
                        state_d = TAIL;
                    end else if ((cnt_q + CW'(1)) == CW'(MAX_FRAME_BITS)) begin
                        state_d = TAIL;
                        err_d   = 1'b1;
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    vld_d  = 1'b1;
                    sym_d  = {c0, c1};
                    last_d = tail_q;
                    s_d    = s_nxt;
                    tail_d = !tail_q;
                    // Second tail symbol closes the frame.
                    if (tail_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        s_d     = 2'b00;
                        tail_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= 2'b00;
            cnt_q   <= '0;
            tail_q  <= 1'b0;
            vld_q   <= 1'b0;
            sym_q   <= 2'b00;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            tail_q  <= tail_d;
            vld_q   <= vld_d;
            sym_q   <= sym_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = vld_q;
    assign out_sym   = sym_q;
    assign out_last  = last_q;
    assign frame_err = err_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Self-checking bench for conv_encoder_framed (MAX 64 and MAX 4 instances).
// Reference: spec-level encoder model, symbol scoreboard and Viterbi loopback.
module tb_conv_encoder_framed;

    localparam logic [2:0] TG0 = 3'b111;
    localparam logic [2:0] TG1 = 3'b101;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    logic       ir_a, ov_a, ol_a, fe_a;
    logic [1:0] sym_a;
    logic [6:0] bc_a;
    logic       ir_b, ov_b, ol_b, fe_b;
    logic [1:0] sym_b;
    logic [2:0] bc_b;

    conv_encoder_framed #(.MAX_FRAME_BITS(64)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && !sel), .in_bit(in_bit), .in_last(in_last),
        .in_ready(ir_a), .out_valid(ov_a), .out_sym(sym_a),
        .out_ready(sel ? 1'b1 : out_ready), .out_last(ol_a),
        .frame_err(fe_a), .bit_count(bc_a)
    );

    conv_encoder_framed #(.MAX_FRAME_BITS(4)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && sel), .in_bit(in_bit), .in_last(in_last),
        .in_ready(ir_b), .out_valid(ov_b), .out_sym(sym_b),
        .out_ready(sel ? out_ready : 1'b1), .out_last(ol_b),
        .frame_err(fe_b), .bit_count(bc_b)
    );

    logic       ir_m, ov_m, last_m, err_m;
    logic [1:0] sym_m;
    logic [6:0] bc_m;
    assign ir_m   = sel ? ir_b : ir_a;
    assign ov_m   = sel ? ov_b : ov_a;
    assign last_m = sel ? ol_b : ol_a;
    assign err_m  = sel ? fe_b : fe_a;
    assign sym_m  = sel ? sym_b : sym_a;
    assign bc_m   = sel ? {4'b0, bc_b} : bc_a;

    typedef struct {
        logic [1:0] sym;
        logic       last;
    } exp_t;

    exp_t       expq[$];
    logic [1:0] rxq[$];
    int         accq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         g_cyc = 0;
    int         maxbits = 64;
    int         fcnt = 0;
    logic [1:0] hist = 2'b00;
    logic       err_exp = 1'b0;
    logic       bc_pend = 1'b0;
    int         bc_exp = 0;
    logic       stall_have = 1'b0;
    logic [1:0] stall_sym = 2'b00;
    logic       stall_last = 1'b0;
    bit         pat[6] = '{1, 0, 0, 1, 0, 1};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Code symbol from the generator definitions: {c0, c1}.
    function automatic logic [1:0] enc(input logic u, input logic [1:0] h);
        logic [2:0] v;
        v = {u, h};
        return {^(v & TG0), ^(v & TG1)};
    endfunction

    task automatic push_sym(input logic u, input logic lst);
        exp_t e;
        e.sym  = enc(u, hist);
        e.last = lst;
        expq.push_back(e);
        hist = {u, hist[1]};
    endtask

    task automatic model_accept(input logic b, input logic l);
        push_sym(b, 1'b0);
        fcnt++;
        bc_exp = fcnt;
        if (l || fcnt == maxbits) begin
            err_exp = !l && (fcnt == maxbits);
            push_sym(1'b0, 1'b0);
            push_sym(1'b0, 1'b1);
            hist = 2'b00;
            fcnt = 0;
        end
    endtask

    task automatic model_clear();
        expq.delete();
        rxq.delete();
        fcnt       = 0;
        hist       = 2'b00;
        err_exp    = 1'b0;
        bc_pend    = 1'b0;
        stall_have = 1'b0;
    endtask

    function automatic bit rdy(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[g_cyc % 6];
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic step(input logic v, input logic b, input logic l,
                        input logic r, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_bit    = b;
        in_last   = l;
        out_ready = r;
        #1;
        g_cyc++;
        check("frame_err", err_m, err_exp);
        if (bc_pend) begin
            check("bit_count", bc_m, bc_exp);
            check("latency", ov_m, 1);
        end
        if (stall_have) begin
            check("stall_valid", ov_m, 1);
            check("stall_sym", sym_m, stall_sym);
            check("stall_last", last_m, stall_last);
        end
        if (ov_m && !r) check("bp_in_ready", ir_m, 0);
        if (ov_m && r) begin
            rxq.push_back(sym_m);
            if (expq.size() == 0) begin
                check("extra_sym", expq.size(), 1);
            end else begin
                e = expq.pop_front();
                check("sym", sym_m, e.sym);
                check("last", last_m, e.last);
            end
        end
        stall_have = ov_m && !r;
        stall_sym  = sym_m;
        stall_last = last_m;
        acc        = v && ir_m;
        err_exp    = 1'b0;
        bc_pend    = acc;
        if (acc) model_accept(b, l);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", ir_m, 0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", ov_m, 0);
        check("rst_out_sym", sym_m, 0);
        check("rst_out_last", last_m, 0);
        check("rst_frame_err", err_m, 0);
        check("rst_bit_count", bc_m, 0);
        model_clear();
    endtask

    task automatic send_bits(input bit bits[$], input bit lasts[$],
                             input int mode);
        bit acc;
        int tries;
        for (int i = 0; i < bits.size(); i++) begin
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 64) begin
                step(1'b1, bits[i], lasts[i], rdy(mode), acc);
                tries++;
            end
            if (!acc) check("accept_timeout", acc, 1);
            else accq.push_back(g_cyc);
        end
    endtask

    task automatic drain(input int mode);
        bit acc;
        int tries;
        tries = 0;
        while (expq.size() != 0 && tries < 400) begin
            step(1'b0, 1'b0, 1'b0, rdy(mode), acc);
            tries++;
        end
        check("drain_empty", expq.size(), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic check_rx(input string tag, input logic [1:0] want[$]);
        check({tag, "_len"}, rxq.size(), want.size());
        for (int i = 0; i < want.size() && i < rxq.size(); i++) begin
            check(tag, rxq[i], want[i]);
        end
    endtask

    // Hard-decision Viterbi over the whole terminated frame.
    function automatic logic [65:0] viterbi(input logic [1:0] rx[$]);
        int          pm[4];
        int          npm[4];
        logic [65:0] path[4];
        logic [65:0] np[4];
        logic [1:0]  sv;
        logic [1:0]  ns;
        logic [1:0]  d;
        int          m;
        pm = '{0, 1000, 1000, 1000};
        for (int k = 0; k < 4; k++) path[k] = '0;
        for (int t = 0; t < rx.size() && t < 66; t++) begin
            for (int k = 0; k < 4; k++) begin
                npm[k] = 100000;
                np[k]  = '0;
            end
            for (int st = 0; st < 4; st++) begin
                for (int u = 0; u < 2; u++) begin
                    sv = st[1:0];
                    ns = {u[0], sv[1]};
                    d  = enc(u[0], sv) ^ rx[t];
                    m  = pm[st] + int'(d[0]) + int'(d[1]);
                    if (m < npm[ns]) begin
                        npm[ns]   = m;
                        np[ns]    = path[st];
                        np[ns][t] = u[0];
                    end
                end
            end
            pm   = npm;
            path = np;
        end
        return path[0];
    endfunction

    initial begin
        bit         bits[$];
        bit         lasts[$];
        logic [1:0] want[$];
        logic [65:0] dec;
        logic [65:0] sent;
        int         n;

        do_reset();

        bits  = '{1, 0, 1, 1};
        lasts = '{0, 0, 0, 1};
        want  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        send_bits(bits, lasts, 0);
        drain(0);
        check_rx("basic", want);

        rxq.delete();
        accq.delete();
        bits  = '{0, 1, 0, 1, 1};
        lasts = '{1, 0, 0, 0, 1};
        send_bits(bits, lasts, 0);
        drain(0);
        want = '{2'b00, 2'b00, 2'b00,
                 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        check_rx("single_b2b", want);
        check("b2b_gap", accq[1] - accq[0], 3);

        rxq.delete();
        bits  = '{1, 0, 1, 1};
        lasts = '{0, 0, 0, 1};
        send_bits(bits, lasts, 1);
        drain(1);
        want = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        check_rx("backpressure", want);

        sel     = 1'b1;
        maxbits = 4;
        do_reset();
        bits  = '{1, 1, 0, 1, 0, 1};
        lasts = '{0, 0, 0, 0, 0, 0};
        send_bits(bits, lasts, 0);
        drain(0);
        want = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b11};
        check_rx("truncate", want);
        check("trunc_bit_count", bc_m, 2);

        sel     = 1'b0;
        maxbits = 64;
        do_reset();
        bits  = '{1, 0};
        lasts = '{0, 0};
        send_bits(bits, lasts, 0);
        do_reset();
        bits  = '{1, 0, 1, 1};
        lasts = '{0, 0, 0, 1};
        send_bits(bits, lasts, 0);
        drain(0);
        want = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        check_rx("after_reset", want);

        for (int f = 0; f < 12; f++) begin
            n = (f == 0) ? 64 : $urandom_range(1, 64);
            bits.delete();
            lasts.delete();
            sent = '0;
            for (int i = 0; i < n; i++) begin
                bits.push_back(1'($urandom_range(0, 1)));
                lasts.push_back(i == n - 1);
                sent[i] = bits[i];
            end
            rxq.delete();
            send_bits(bits, lasts, 2);
            drain(2);
            check("loop_len", rxq.size(), n + 2);
            dec = viterbi(rxq);
            check("loop_lo", dec[31:0], sent[31:0]);
            check("loop_hi", dec[65:32], sent[65:32]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
